// File: rtl/audio_minmax_pkg.sv
// Shared types and width helpers for the streaming audio min/max block.
package audio_minmax_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam state_t ST_RST  = IDLE;
  localparam logic   OUT_RST = 1'b0;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/audio_min_max_stream_if.sv
// Sample-in / result-out handshake bundle of the audio min/max block.
interface audio_min_max_stream_if #(
  parameter int WIDTH = 32,
  parameter int CH_W  = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_sample;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] out_min;
  logic signed [WIDTH-1:0] out_max;
  logic [WIDTH:0]          out_p2p;

  modport master (
    output in_valid, in_ch, in_sample, out_ready,
    input  in_ready, out_valid, out_ch, out_min, out_max, out_p2p
  );

  modport slave (
    input  in_valid, in_ch, in_sample, out_ready,
    output in_ready, out_valid, out_ch, out_min, out_max, out_p2p
  );
endinterface

// File: rtl/minmax_lane.sv
// One channel's running min/max and window counter; min_nxt/max_nxt already include the current sample.
module minmax_lane
  import audio_minmax_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WIN   = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    upd,
  input  logic signed [WIDTH-1:0] sample,
  output logic signed [WIDTH-1:0] min_nxt,
  output logic signed [WIDTH-1:0] max_nxt,
  output logic                    wrap
);
  localparam int CNT_W = cnt_w(WIN);

  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] mn, mx;
  logic                    first;

  assign first = (cnt == '0);
  assign wrap  = upd && (cnt == CNT_W'(WIN - 1));

  always_comb begin
    min_nxt = (first || sample < mn) ? sample : mn;
    max_nxt = (first || sample > mx) ? sample : mx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      mn  <= '0;
      mx  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (upd) begin
      mn  <= min_nxt;
      mx  <= max_nxt;
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_min_max_stream.sv
// Multi-channel windowed min/max/peak-to-peak tracker with one-entry result register.
module audio_min_max_stream
  import audio_minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int WIN    = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cont_mode,
  audio_min_max_stream_if.slave  bus,
  output logic                   d
);
  localparam int CH_W = ch_w(NUM_CH);

  state_t                         state, state_nxt;
  logic                           cont_q, ov_q, rdy, acc;
  logic [NUM_CH-1:0]              done_q, upd, wrap;
  logic [NUM_CH-1:0][WIDTH-1:0]   lane_min, lane_max;
  logic [CH_W-1:0]                res_ch;
  logic [WIDTH-1:0]               res_min, res_max;

  assign rdy           = (state == RUN) && !start && (!ov_q || bus.out_ready);
  assign acc           = bus.in_valid && rdy;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov_q;
  assign d             = (state == DONE);

  // Out-of-range channels match no lane, so they are consumed without effect.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign upd[g] = acc && (bus.in_ch == CH_W'(g)) && !(!cont_q && done_q[g]);

    minmax_lane #(.WIDTH(WIDTH), .WIN(WIN)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (start),
      .upd     (upd[g]),
      .sample  (bus.in_sample),
      .min_nxt (lane_min[g]),
      .max_nxt (lane_max[g]),
      .wrap    (wrap[g])
    );
  end

  always_comb begin
    res_ch  = '0;
    res_min = '0;
    res_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrap[i]) begin
        res_ch  = CH_W'(i);
        res_min = lane_min[i];
        res_max = lane_max[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (!start && !cont_q && (&done_q) && !ov_q) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RST;
      cont_q <= 1'b0;
      done_q <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cont_q <= cont_mode;
        done_q <= '0;
      end else begin
        done_q <= done_q | (cont_q ? '0 : wrap);
      end
    end
  end

  // A completion wins over a same-cycle handoff so the new result is never dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ov_q        <= OUT_RST;
      bus.out_ch  <= '0;
      bus.out_min <= '0;
      bus.out_max <= '0;
      bus.out_p2p <= '0;
    end else if (|wrap) begin
      ov_q        <= 1'b1;
      bus.out_ch  <= res_ch;
      bus.out_min <= res_min;
      bus.out_max <= res_max;
      bus.out_p2p <= {res_max[WIDTH-1], res_max} - {res_min[WIDTH-1], res_min};
    end else if (ov_q && bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_min_max_stream.sv
// Randomized bench for audio_min_max_stream against a window-list reference model.
module tb_audio_min_max_stream;
  localparam int WIDTH  = 32;
  localparam int NUM_CH = 3;
  localparam int WIN    = 100;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic reset, start, cont_mode, d;
  bit   hold_rdy;
  int   n_cmp, n_err;

  audio_min_max_stream_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  audio_min_max_stream #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .WIN(WIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cont_mode (cont_mode),
    .bus       (bus),
    .d         (d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", tag, $time);
  endtask

  // Reference model: keeps each channel's window as a plain list of samples.
  typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
  mst_t                   m_state;
  bit                     m_cont, m_ov;
  bit                     m_done[NUM_CH];
  logic signed [31:0]     m_win[NUM_CH][$];
  logic [CH_W-1:0]        m_ch;
  logic signed [31:0]     m_min, m_max;
  logic [32:0]            m_p2p;
  int                     n_results;

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_win[c].delete();
      m_done[c] = 0;
    end
  endtask

  initial forever begin
    bit hs, acc, all_done, nov, exp_rdy;
    int ch;
    logic signed [31:0] mn, mx;
    @(negedge clk);
    if (!reset) begin
      model_clear();
      m_state = M_IDLE; m_cont = 0; m_ov = 0;
      m_ch = '0; m_min = '0; m_max = '0; m_p2p = '0;
    end
    exp_rdy = reset && (m_state == M_RUN) && !start && (!m_ov || bus.out_ready);
    chk("in_ready",  bus.in_ready,  exp_rdy);
    chk("out_valid", bus.out_valid, m_ov);
    chk("d",         d,             m_state == M_DONE);
    chk("out_ch",    bus.out_ch,    m_ch);
    chk("out_min",   bus.out_min,   m_min);
    chk("out_max",   bus.out_max,   m_max);
    chk("out_p2p",   bus.out_p2p,   m_p2p);
    if (reset) begin
      hs  = m_ov && bus.out_ready;
      acc = bus.in_valid && exp_rdy;
      nov = m_ov && !hs;
      all_done = 1;
      for (int c = 0; c < NUM_CH; c++) if (!m_done[c]) all_done = 0;
      if (start) begin
        m_state = M_RUN;
        m_cont  = cont_mode;
        model_clear();
      end else if (m_state == M_RUN) begin
        if (!m_cont && all_done && !m_ov) m_state = M_DONE;
        ch = int'(bus.in_ch);
        if (acc && ch < NUM_CH && (m_cont || !m_done[ch])) begin
          m_win[ch].push_back(bus.in_sample);
          if (m_win[ch].size() == WIN) begin
            mn = m_win[ch][0];
            mx = m_win[ch][0];
            foreach (m_win[ch][k]) begin
              if (m_win[ch][k] < mn) mn = m_win[ch][k];
              if (m_win[ch][k] > mx) mx = m_win[ch][k];
            end
            m_ch  = bus.in_ch;
            m_min = mn;
            m_max = mx;
            m_p2p = 33'(longint'(mx) - longint'(mn));
            nov   = 1;
            n_results++;
            m_win[ch].delete();
            if (!m_cont) m_done[ch] = 1;
          end
        end
      end
      m_ov = nov;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int ch, input logic signed [31:0] s);
    if ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b1;
    bus.in_ch     = CH_W'(ch);
    bus.in_sample = s;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic pulse_start(input logic c);
    start = 1'b1; cont_mode = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_d();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (d) begin
        @(posedge clk); #1;
        return;
      end
    end
    timeout("wait_d");
  endtask

  function automatic logic signed [31:0] rnd();
    return $signed($urandom());
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; cont_mode = 1'b0; hold_rdy = 0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_sample = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // One-shot: ramp on ch0, constant on ch1, then alternating on ch2; junk on ch3.
    pulse_start(1'b0);
    for (int i = 0; i < WIN; i++) begin
      send(0, i);
      send(1, 42);
      if ($urandom_range(0, 4) == 0) send(3, rnd());
    end
    repeat (3) send(0, -5000);
    for (int i = 0; i < WIN; i++) send(2, (i % 2) ? 100 : -100);
    wait_d();
    repeat (4) @(posedge clk);
    #1;

    // Continuous: random windows with full-scale extremes; backpressure on one completion.
    pulse_start(1'b1);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WIN; i++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (c == 0 && w == 1 && i == WIN - 1) begin
            send(0, rnd());
            hold_rdy = 1;
            bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_sample = 32'sd555;
            repeat (10) @(posedge clk);
            #1 hold_rdy = 0;
          end else if (c == 0 && i == 10) send(0, 32'sh8000_0000);
          else if (c == 0 && i == 60) send(0, 32'sh7fff_ffff);
          else send(c, rnd());
        end
        if ($urandom_range(0, 7) == 0) send(3, rnd());
      end
    end
    repeat (10) @(posedge clk);
    #1;

    // Restart in RUN with a sample offered in the start cycle, then reset mid-window.
    for (int i = 0; i < 30; i++) send(i % NUM_CH, rnd());
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_sample = 32'sh7fff_fff0;
    pulse_start(1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 50; i++) send(0, rnd());
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_min",   bus.out_min,   0);
    chk("rst_out_p2p",   bus.out_p2p,   0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(1'b0);
    for (int i = 0; i < WIN; i++)
      for (int c = 0; c < NUM_CH; c++) send(c, $signed(32'($urandom_range(0, 2000))) - 1000);
    wait_d();
    repeat (4) @(posedge clk);

    chk("result_count", n_results, 3 + 9 + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
